mux4_dual_impl_cmp: RTL and testbench

- 4:1 single-bit multiplexer built twice: once from 2-input NAND primitives only, once from notif1 tri-state drivers on a shared net.
- Both results are exposed combinationally, registered, and cross-checked each cycle.
- Used as a gate-level lab block to compare implementation styles (function equivalence, propagation delay) inside a clocked wrapper.

---
 rtl/mux4_pkg.sv | 25 ++
 rtl/mux4_core.sv | 88 ++++++++
 rtl/mux4_dual_impl_cmp.sv | 63 ++++++
 tb/tb_mux4_dual_impl_cmp.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// Shared constants for the dual-implementation 4:1 mux lab block.
`timescale 1ns/1ns
package mux4_pkg;

    // Select encodings, sel = {s1, s0}
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    // Implementation selector for mux4_core
    localparam int IMPL_NAND = 0;
    localparam int IMPL_TRI  = 1;

    // Default per-gate simulation delays in ns
    localparam int NAND_DLY_DEF = 1;
    localparam int TRI_DLY_DEF  = 1;

    // Longest gate chain of each implementation, in gate delays:
    // NAND: select inverter + 3-level product term + 3-level 4-input NAND
    // tri-state: select inverter + enable AND + driver stage
    localparam int NAND_CHAIN = 7;
    localparam int TRI_CHAIN  = 3;

endpackage

// File: rtl/mux4_core.sv
// Gate-level 4:1 single-bit mux; IMPL picks 2-input NAND or notif1 structure.
`timescale 1ns/1ns
module mux4_core
    import mux4_pkg::*;
#(
    parameter int IMPL = IMPL_NAND,
    parameter int DLY  = 1
) (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic s0,
    input  logic s1,
    output logic w
);

    if (IMPL == IMPL_NAND) begin : g_nand
        wire s0_n, s1_n;
        wire ta_1, ta_2, term_a;
        wire tb_1, tb_2, term_b;
        wire tc_1, tc_2, term_c;
        wire td_1, td_2, term_d;
        wire p_ab, p_ab_and, p_cd, p_cd_and, w_int;

        // select inverters: NANDs with tied inputs
        nand #(DLY) u_inv_s0 (s0_n, s0, s0);
        nand #(DLY) u_inv_s1 (s1_n, s1, s1);

        // term_a = NAND(a, ~s1, ~s0) as NAND -> NAND-inverter -> NAND
        nand #(DLY) u_ta1 (ta_1, a, s1_n);
        nand #(DLY) u_ta2 (ta_2, ta_1, ta_1);
        nand #(DLY) u_ta3 (term_a, ta_2, s0_n);

        // term_b = NAND(b, ~s1, s0)
        nand #(DLY) u_tb1 (tb_1, b, s1_n);
        nand #(DLY) u_tb2 (tb_2, tb_1, tb_1);
        nand #(DLY) u_tb3 (term_b, tb_2, s0);

        // term_c = NAND(c, s1, ~s0)
        nand #(DLY) u_tc1 (tc_1, c, s1);
        nand #(DLY) u_tc2 (tc_2, tc_1, tc_1);
        nand #(DLY) u_tc3 (term_c, tc_2, s0_n);

        // term_d = NAND(d, s1, s0)
        nand #(DLY) u_td1 (td_1, d, s1);
        nand #(DLY) u_td2 (td_2, td_1, td_1);
        nand #(DLY) u_td3 (term_d, td_2, s0);

        // 4-input NAND of the terms = NAND(AND(ta,tb), AND(tc,td))
        nand #(DLY) u_f1 (p_ab, term_a, term_b);
        nand #(DLY) u_f2 (p_ab_and, p_ab, p_ab);
        nand #(DLY) u_f3 (p_cd, term_c, term_d);
        nand #(DLY) u_f4 (p_cd_and, p_cd, p_cd);
        nand #(DLY) u_f5 (w_int, p_ab_and, p_cd_and);

        // expose the NAND tree output
        assign w = w_int;
    end else begin : g_tri
        wire s0_n, s1_n;
        wire en_a, en_b, en_c, en_d;
        wire a_n, b_n, c_n, d_n;
        wire w_bus;

        // one-hot enable decode from the selects
        not #(DLY) u_inv_s0 (s0_n, s0);
        not #(DLY) u_inv_s1 (s1_n, s1);
        and #(DLY) u_en_a (en_a, s1_n, s0_n);
        and #(DLY) u_en_b (en_b, s1_n, s0);
        and #(DLY) u_en_c (en_c, s1,   s0_n);
        and #(DLY) u_en_d (en_d, s1,   s0);

        // drivers invert, so feed them the inverted data to get true polarity on the bus
        not #(DLY) u_inv_a (a_n, a);
        not #(DLY) u_inv_b (b_n, b);
        not #(DLY) u_inv_c (c_n, c);
        not #(DLY) u_inv_d (d_n, d);

        notif1 u_drv_a (w_bus, a_n, en_a);
        notif1 u_drv_b (w_bus, b_n, en_b);
        notif1 u_drv_c (w_bus, c_n, en_c);
        notif1 u_drv_d (w_bus, d_n, en_d);

        // driver propagation delay is lumped onto the bus-to-output stage
        assign #(DLY) w = w_bus;
    end

endmodule

// File: rtl/mux4_dual_impl_cmp.sv
// Clocked wrapper: both mux implementations, registered outputs, cross-check and mismatch counter.
`timescale 1ns/1ns
module mux4_dual_impl_cmp
    import mux4_pkg::*;
#(
    parameter int NAND_DLY = NAND_DLY_DEF,
    parameter int TRI_DLY  = TRI_DLY_DEF,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             s0,
    input  logic             s1,
    output logic             w_nand,
    output logic             w_tri,
    output logic             w_nand_q,
    output logic             w_tri_q,
    output logic             mismatch_q,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic mismatch_p0;

    // increment by one unless already at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        if (inc && (cnt != {CNT_W{1'b1}}))
            return cnt + CNT_ONE;
        return cnt;
    endfunction

    mux4_core #(.IMPL(IMPL_NAND), .DLY(NAND_DLY)) u_nand (
        .a(a), .b(b), .c(c), .d(d), .s0(s0), .s1(s1), .w(w_nand)
    );

    mux4_core #(.IMPL(IMPL_TRI), .DLY(TRI_DLY)) u_tri (
        .a(a), .b(b), .c(c), .d(d), .s0(s0), .s1(s1), .w(w_tri)
    );

    // case-inequality so an X or Z on either side is flagged
    assign mismatch_p0 = (w_nand !== w_tri);

    // stage p0 -> q: register both results, the flag and the saturating count
    always_ff @(posedge clk) begin
        if (rst) begin
            w_nand_q     <= 1'b0;
            w_tri_q      <= 1'b0;
            mismatch_q   <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            w_nand_q     <= w_nand;
            w_tri_q      <= w_tri;
            mismatch_q   <= mismatch_p0;
            mismatch_cnt <= sat_inc(mismatch_cnt, mismatch_p0);
        end
    end

endmodule

// File: tb/tb_mux4_dual_impl_cmp.sv
// Directed-vector bench for mux4_dual_impl_cmp.
`timescale 1ns/1ns
module tb_mux4_dual_impl_cmp;
    import mux4_pkg::*;

    localparam int CNT_W = 8;
    localparam int NDLY  = NAND_DLY_DEF;
    localparam int TDLY  = TRI_DLY_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, s0 = 1'b0, s1 = 1'b0;
    logic w_nand, w_tri, w_nand_q, w_tri_q, mismatch_q;
    logic [CNT_W-1:0] mismatch_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mux4_dual_impl_cmp #(.NAND_DLY(NDLY), .TRI_DLY(TDLY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .a(a), .b(b), .c(c), .d(d), .s0(s0), .s1(s1),
        .w_nand(w_nand), .w_tri(w_tri),
        .w_nand_q(w_nand_q), .w_tri_q(w_tri_q),
        .mismatch_q(mismatch_q), .mismatch_cnt(mismatch_cnt)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_mux(input logic [5:0] v);
        // v = {a,b,c,d,s1,s0}
        logic [1:0] sel;
        sel = v[1:0];
        case (sel)
            SEL_A:   return v[5];
            SEL_B:   return v[4];
            SEL_C:   return v[3];
            default: return v[2];
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] v;
        logic       exp_w;
        int         last_n, last_t;

        // reset with arbitrary inputs
        {a, b, c, d, s1, s0} = 6'b101101;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_w_nand_q", 32'(w_nand_q), 32'd0);
        chk("rst_w_tri_q", 32'(w_tri_q), 32'd0);
        chk("rst_mismatch_q", 32'(mismatch_q), 32'd0);
        chk("rst_cnt", 32'(mismatch_cnt), 32'd0);
        rst = 1'b0;

        // select 11
        {a, b, c, d, s1, s0} = 6'b011111;
        #20;
        chk("s11_w_nand", 32'(w_nand), 32'd1);
        chk("s11_w_tri", 32'(w_tri), 32'd1);
        tick();
        chk("s11_w_nand_q", 32'(w_nand_q), 32'd1);
        chk("s11_w_tri_q", 32'(w_tri_q), 32'd1);
        a = 1'b1;
        #20;
        chk("s11a_w_nand", 32'(w_nand), 32'd1);
        chk("s11a_w_tri", 32'(w_tri), 32'd1);
        tick();
        chk("s11a_mismatch_q", 32'(mismatch_q), 32'd0);
        chk("s11a_cnt", 32'(mismatch_cnt), 32'd0);

        // select 00, then flip s0
        {a, b, c, d, s1, s0} = 6'b100000;
        #20;
        chk("s00_w_nand", 32'(w_nand), 32'd1);
        chk("s00_w_tri", 32'(w_tri), 32'd1);
        tick();
        chk("s00_w_nand_q", 32'(w_nand_q), 32'd1);
        s0 = 1'b1;
        #20;
        chk("s01_w_nand", 32'(w_nand), 32'd0);
        chk("s01_w_tri", 32'(w_tri), 32'd0);
        chk("s01_w_tri_q_old", 32'(w_tri_q), 32'd1);
        tick();
        chk("s01_w_nand_q", 32'(w_nand_q), 32'd0);
        chk("s01_w_tri_q", 32'(w_tri_q), 32'd0);

        // exhaustive sweep of {a,b,c,d,s1,s0}
        for (int i = 0; i < 64; i++) begin
            v = 6'(i);
            {a, b, c, d, s1, s0} = v;
            exp_w = ref_mux(v);
            #20;
            chk($sformatf("sw%0d_w_nand", i), 32'(w_nand), 32'(exp_w));
            chk($sformatf("sw%0d_w_tri", i), 32'(w_tri), 32'(exp_w));
            tick();
            chk($sformatf("sw%0d_w_nand_q", i), 32'(w_nand_q), 32'(exp_w));
            chk($sformatf("sw%0d_w_tri_q", i), 32'(w_tri_q), 32'(exp_w));
            chk($sformatf("sw%0d_mismatch_q", i), 32'(mismatch_q), 32'd0);
        end
        chk("sweep_cnt", 32'(mismatch_cnt), 32'd0);

        // counter saturation: X on the select plus a pinned NAND output
        // guarantees disagreement under both 2-state and 4-state simulation
        {a, b, c, d, s1} = 5'b11110;
        s0 = 1'bx;
        force dut.w_nand = 1'b0;
        #20;
        tick();
        chk("sat_first_mismatch_q", 32'(mismatch_q), 32'd1);
        chk("sat_first_cnt", 32'(mismatch_cnt), 32'd1);
        for (int i = 1; i < (1 << CNT_W) + 3; i++) tick();
        chk("sat_cnt_hold", 32'(mismatch_cnt), 32'd255);
        chk("sat_mismatch_q", 32'(mismatch_q), 32'd1);
        rst = 1'b1;
        tick();
        chk("sat_rst_cnt", 32'(mismatch_cnt), 32'd0);
        chk("sat_rst_mismatch_q", 32'(mismatch_q), 32'd0);
        rst = 1'b0;
        tick();
        chk("sat_restart_cnt", 32'(mismatch_cnt), 32'd1);
        release dut.w_nand;
        s0 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // delay comparison: sel 01 -> 10 with b=1, c=0
        {a, b, c, d, s1, s0} = 6'b010001;
        #20;
        chk("dly_pre_w_nand", 32'(w_nand), 32'd1);
        chk("dly_pre_w_tri", 32'(w_tri), 32'd1);
        {s1, s0} = 2'b10;
        last_n = 0;
        last_t = 0;
        for (int t = 1; t <= 2 * NAND_CHAIN * NDLY + 2; t++) begin
            #1;
            if (w_nand !== 1'b0) last_n = t;
            if (w_tri !== 1'b0) last_t = t;
        end
        chk("dly_nand_final", 32'(w_nand), 32'd0);
        chk("dly_tri_final", 32'(w_tri), 32'd0);
        chk("dly_nand_in_budget", 32'(last_n <= NAND_CHAIN * NDLY), 32'd1);
        chk("dly_tri_in_budget", 32'(last_t <= TRI_CHAIN * TDLY), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // hard stop in case something stalls the clocked flow
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
